jtbubl_gfx_romfetch: RTL and testbench
======================================

// Module: jtbubl_gfx_romfetch
// PURPOSE
// - Fetch stage between the video block's graphics ROM port and the SDRAM controller.
// - Video side: jtframe-style rom_cs/rom_addr/rom_data/rom_ok. SDRAM side: req/ack/data-ready.
// - Small fully-associative cache of ENTRIES words. Repeated tile/object fetches hit without SDRAM traffic.
// PARAMETERS
// - AW       18   address width (32-bit word address)
// - DW       32   data width
// - ENTRIES  2    cache entries, power of two, 2..8
// - TIMEOUT  255  max cycles waiting for sdram_rdy before the request is dropped and reissued
// PORTS
// - rst        in   1   asynchronous reset, active high
// - clk        in   1   single system clock (48 MHz); no other clock used
// - flush      in   1   invalidate all entries (ROM download/PROM load)
// - rom_cs     in   1   video requests data at rom_addr
// - rom_addr   in   AW  requested word address
// - rom_data   out  DW  data for rom_addr; valid only while rom_ok=1
// - rom_ok     out  1   rom_data matches the current rom_addr
// - sdram_addr out  AW  address of the outstanding SDRAM read
// - sdram_req  out  1   read request; held until sdram_ack
// - sdram_ack  in   1   controller accepted the request
// - sdram_rdy  in   1   sdram_data valid for the accepted request; 1-cycle pulse
// - sdram_data in   DW  read data
// BEHAVIOUR
// - Reset: all valid bits 0, replacement pointer 0, state IDLE, sdram_req 0, sdram_addr 0,
//   rom_ok 0, rom_data 0, timeout counter 0.
// - Hit: rom_cs & some valid entry tag==rom_addr.
// - rom_ok = hit, combinational from registered tags. rom_data = hitting entry, else 0.
// - Hit latency 0 cycles after the entry is written.
// - rom_ok drops in the same cycle rom_addr changes to a non-resident address.
// - FSM states, held in the shared package:
//   - IDLE: rom_cs & !hit -> latch sdram_addr<=rom_addr, set sdram_req, go REQ.
//   - REQ: sdram_ack -> clear sdram_req, clear counter, go WAIT.
//   - WAIT: sdram_rdy -> FILL. Counter reaches TIMEOUT -> IDLE with nothing written; the miss is re-evaluated.
//   - FILL: write data/tag to entry[ptr], set valid, ptr<=ptr+1 (wraps at ENTRIES), go IDLE.
//     Earliest rom_ok is the cycle after FILL.
// - Miss-to-ok latency = ack delay + rdy delay + 2 cycles.
// - Exactly one outstanding SDRAM request at any time.
// - Address change during REQ/WAIT: the fetch completes and fills normally. The new address is handled from IDLE.
// - rom_cs low during REQ/WAIT: same as an address change; the fetch still completes and fills.
// - flush: clears all valid bits in that cycle.
//   - flush in WAIT or FILL: the returning word is discarded and the valid bit stays 0.
//   - flush & FILL in the same cycle: flush wins.
//   - sdram_req is not withdrawn by flush.
// - Same address already resident at FILL time (duplicate after flush race): the fill still writes.
//   Hit selection takes the lowest-index matching entry.
// - sdram_rdy outside WAIT is ignored.
// - sdram_ack outside REQ is ignored.
// - Counter width is clog2(TIMEOUT+1) and saturates. TIMEOUT=0 disables the timeout.
// STRUCTURE
// - Package jtbubl_romfetch_pkg: state enum {IDLE,REQ,WAIT,FILL}, PTR_W=clog2(ENTRIES).
// - Sub-module jtbubl_romfetch_tags: tag/valid/data arrays, priority hit encoder,
//   round-robin pointer, write port. The top level holds the FSM, the counter and the SDRAM handshake.
// TESTING
// - Miss: rom_cs=1, addr=0x00123; ack at +2, rdy(data=0xDEADBEEF) at +5
//   -> rom_ok=1 at +7 with rom_data=0xDEADBEEF; one sdram_req pulse train.
// - Hit: alternate 0x00123/0x00200 after both are filled
//   -> rom_ok every cycle, sdram_req stays 0.
// - Eviction (ENTRIES=2): fill A,B,C, then request A
//   -> new SDRAM read of A, written into entry 1 (B evicted), so C and A resident.
// - Address change in WAIT: addr 0x10 -> 0x20 before rdy
//   -> 0x10 filled, then a new request for 0x20; rom_ok never 1 with 0x10 data while addr=0x20.
// - flush in WAIT: rdy arrives, then request same addr
//   -> rom_ok stays 0, second SDRAM read issued.
// - Timeout (TIMEOUT=8): ack, no rdy -> after 8 WAIT cycles sdram_req reasserts for the same address.
//   Async rst mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/jtbubl_romfetch_pkg.sv
// Shared types and width helpers for the graphics ROM fetch stage and its tag store.
package jtbubl_romfetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } fetch_state_t;

  // Replacement pointer width (PTR_W); a single entry still needs one bit.
  function automatic int ptr_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // A timeout of 0 disables the timer, but the counter still needs a bit.
  function automatic int cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/jtbubl_romfetch_tags.sv
// Fully-associative word cache: tag/valid/data arrays, lowest-index hit select,
// round-robin replacement pointer and a single write port.
module jtbubl_romfetch_tags
  import jtbubl_romfetch_pkg::*;
#(
  parameter int AW      = 18,
  parameter int DW      = 32,
  parameter int ENTRIES = 2
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          we,
  input  logic [AW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_tag,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  localparam int PW = ptr_w(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [AW-1:0]      tag  [ENTRIES];
  logic [DW-1:0]      data [ENTRIES];
  logic [PW-1:0]      ptr;

  // A flush in the same cycle as a write leaves the entry invalid and the pointer put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      ptr   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (we && !flush) begin
        tag[ptr]   <= wr_tag;
        data[ptr]  <= wr_data;
        valid[ptr] <= 1'b1;
        ptr        <= ptr + 1'b1;
      end
      if (flush) valid <= '0;
    end
  end

  // Scan downwards so the lowest matching index is the one left selected.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == rd_tag) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

endmodule

// File: rtl/jtbubl_gfx_romfetch.sv
// Graphics ROM fetch stage: serves video ROM reads from a small cache and
// refills misses from SDRAM with one outstanding request at a time.
//
//   state | meaning
//   IDLE  | no fetch in flight; a miss on rom_addr launches one
//   REQ   | sdram_req held until the controller acks
//   WAIT  | accepted, waiting for sdram_rdy or the timeout
//   FILL  | latched word written into the cache (unless discarded)
module jtbubl_gfx_romfetch
  import jtbubl_romfetch_pkg::*;
#(
  parameter int AW      = 18,
  parameter int DW      = 32,
  parameter int ENTRIES = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_data,
  output logic          rom_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [DW-1:0] sdram_data
);

  localparam int          CW     = cnt_w(TIMEOUT);
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT);

  fetch_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW:0]   cnt_inc;
  logic          timed_out;
  logic          discard, discard_nxt;
  logic          req_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] fill_data, fill_data_nxt;
  logic          fill_we;
  logic          hit;
  logic [DW-1:0] hit_data;

  jtbubl_romfetch_tags #(
    .AW      (AW),
    .DW      (DW),
    .ENTRIES (ENTRIES)
  ) u_tags (
    .rst      (rst),
    .clk      (clk),
    .flush    (flush),
    .we       (fill_we),
    .wr_tag   (sdram_addr),
    .wr_data  (fill_data),
    .rd_tag   (rom_addr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  assign rom_ok    = rom_cs & hit;
  assign rom_data  = rom_ok ? hit_data : '0;
  assign cnt_inc   = {1'b0, cnt} + 1'b1;
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == TO_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      cnt        <= '0;
      discard    <= 1'b0;
      fill_data  <= '0;
    end else begin
      state      <= state_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
      cnt        <= cnt_nxt;
      discard    <= discard_nxt;
      fill_data  <= fill_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_nxt       = sdram_req;
    addr_nxt      = sdram_addr;
    cnt_nxt       = cnt;
    discard_nxt   = discard;
    fill_data_nxt = fill_data;
    fill_we       = 1'b0;
    case (state)
      IDLE: begin
        if (rom_cs && !hit) begin
          addr_nxt    = rom_addr;
          req_nxt     = 1'b1;
          discard_nxt = 1'b0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (sdram_rdy) begin
          fill_data_nxt = sdram_data;
          state_nxt     = FILL;
        end else begin
          if (!(&cnt)) cnt_nxt = cnt_inc[CW-1:0];
          if (timed_out) state_nxt = IDLE;
        end
      end
      FILL: begin
        fill_we   = !discard;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A word fetched across a flush may predate the new ROM contents.
    if (flush && (state == REQ || state == WAIT)) discard_nxt = 1'b1;
  end

endmodule

// File: tb/tb_jtbubl_gfx_romfetch.sv
// Directed bench for jtbubl_gfx_romfetch: transaction-level cache model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_jtbubl_gfx_romfetch;

  localparam int AW = 18, DW = 32, ENTRIES = 2, TIMEOUT = 8;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, rom_cs = 1'b0;
  logic          sdram_ack = 1'b0, sdram_rdy = 1'b0;
  logic [AW-1:0] rom_addr = '0;
  logic [DW-1:0] sdram_data = '0;
  logic [DW-1:0] rom_data;
  logic          rom_ok, sdram_req;
  logic [AW-1:0] sdram_addr;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  jtbubl_gfx_romfetch #(.AW(AW), .DW(DW), .ENTRIES(ENTRIES), .TIMEOUT(TIMEOUT)) dut (
    .rst(rst), .clk(clk), .flush(flush), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_data(sdram_data)
  );

  // Model: cache contents plus the life of the single SDRAM transaction.
  bit            m_valid [ENTRIES];
  logic [AW-1:0] m_tag   [ENTRIES];
  logic [DW-1:0] m_data  [ENTRIES];
  int            m_ptr = 0;
  bit            t_live = 0, t_acc = 0, t_got = 0, t_drop = 0, was_pending;
  int            t_wait = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] t_data = '0;

  function automatic bit m_lookup(input logic [AW-1:0] a, output logic [DW-1:0] d);
    d = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == a) begin
        d = m_data[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [DW-1:0] dummy;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_ptr = 0; t_live = 0; t_acc = 0; t_got = 0; t_drop = 0; t_wait = 0; m_addr = '0;
    end else begin
      was_pending = t_live && !t_got;
      if (t_live && t_got) begin
        if (!flush && !t_drop) begin
          m_valid[m_ptr] = 1'b1; m_tag[m_ptr] = m_addr; m_data[m_ptr] = t_data;
          m_ptr = (m_ptr + 1) % ENTRIES;
        end
        t_live = 0;
      end else if (t_live && !t_acc) begin
        if (sdram_ack) begin t_acc = 1; t_wait = 0; end
      end else if (t_live) begin
        if (sdram_rdy) begin t_got = 1; t_data = sdram_data; end
        else begin
          t_wait++;
          if (t_wait == TIMEOUT) t_live = 0;
        end
      end else if (rom_cs && !m_lookup(rom_addr, dummy)) begin
        t_live = 1; t_acc = 0; t_got = 0; t_drop = 0; m_addr = rom_addr;
      end
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        if (was_pending) t_drop = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [DW-1:0] ed;
    bit eh;
    eh = rom_cs && m_lookup(rom_addr, ed);
    check("cyc_rom_ok", {31'd0, rom_ok}, {31'd0, eh});
    check("cyc_rom_data", rom_data, eh ? ed : '0);
    check("cyc_sdram_req", {31'd0, sdram_req}, {31'd0, t_live && !t_acc});
    check("cyc_sdram_addr", {14'd0, sdram_addr}, {14'd0, m_addr});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Answer the pending request: ack, then rdy one cycle later; ends in the cycle after FILL.
  task automatic serve(input logic [DW-1:0] d);
    int n = 0;
    while (!sdram_req && n < 20) begin tick(); n++; end
    check("serve_req_seen", {31'd0, sdram_req}, 32'd1);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    sdram_data = d; sdram_rdy = 1'b1; tick(); sdram_rdy = 1'b0; sdram_data = '0;
    tick();
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rom_cs = 1'b1; rom_addr = a;
    serve(d);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Reset values
    tick(); tick();
    check("rst_rom_ok", {31'd0, rom_ok}, 32'd0);
    check("rst_rom_data", rom_data, 32'd0);
    check("rst_sdram_req", {31'd0, sdram_req}, 32'd0);
    check("rst_sdram_addr", {14'd0, sdram_addr}, 32'd0);
    rst = 1'b0;

    // Miss: ack at +2, rdy at +5, ok at +7
    tick(); rom_cs = 1'b1; rom_addr = 18'h00123;
    tick(); check("miss_req_c1", {31'd0, sdram_req}, 32'd1);
    check("miss_addr_c1", {14'd0, sdram_addr}, 32'h123);
    tick(); check("miss_req_c2", {31'd0, sdram_req}, 32'd1); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0; check("miss_req_c3", {31'd0, sdram_req}, 32'd0);
    tick();
    tick(); sdram_rdy = 1'b1; sdram_data = 32'hDEADBEEF;
    tick(); sdram_rdy = 1'b0; sdram_data = '0; #1;
    check("miss_ok_c6", {31'd0, rom_ok}, 32'd0);
    tick(); check("miss_ok_c7", {31'd0, rom_ok}, 32'd1);
    check("miss_data_c7", rom_data, 32'hDEADBEEF);

    // Hit: alternate two resident words, with stray ack/rdy that must be ignored
    fetch(18'h00200, 32'hCAFE0200);
    for (int i = 0; i < 10; i++) begin
      rom_addr  = (i % 2) ? 18'h00200 : 18'h00123;
      sdram_ack = (i == 3);
      sdram_rdy = (i == 5);
      sdram_data = (i == 5) ? 32'h55555555 : '0;
      #1;
      check("hit_ok", {31'd0, rom_ok}, 32'd1);
      check("hit_data", rom_data, (i % 2) ? 32'hCAFE0200 : 32'hDEADBEEF);
      check("hit_no_req", {31'd0, sdram_req}, 32'd0);
      tick();
    end
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_data = '0;

    // Eviction: A,B,C then A again evicts B
    fetch(18'h00300, 32'hAAAA0001);
    fetch(18'h00301, 32'hBBBB0001);
    fetch(18'h00302, 32'hCCCC0001);
    rom_addr = 18'h00300; #1;
    check("evict_a_gone", {31'd0, rom_ok}, 32'd0);
    serve(32'hAAAA0002);
    check("evict_refetch_addr", {14'd0, sdram_addr}, 32'h300);
    check("evict_a_ok", {31'd0, rom_ok}, 32'd1);
    check("evict_a_data", rom_data, 32'hAAAA0002);
    rom_addr = 18'h00302; #1;
    check("evict_c_ok", {31'd0, rom_ok}, 32'd1);
    check("evict_c_data", rom_data, 32'hCCCC0001);
    rom_addr = 18'h00301; #1;
    check("evict_b_gone", {31'd0, rom_ok}, 32'd0);
    rom_cs = 1'b0;

    // Address change while waiting for data
    tick(); rom_cs = 1'b1; rom_addr = 18'h00010;
    tick(); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0; rom_addr = 18'h00020; #1;
    check("chg_wait_ok", {31'd0, rom_ok}, 32'd0);
    tick(); sdram_rdy = 1'b1; sdram_data = 32'h10101010;
    tick(); sdram_rdy = 1'b0; sdram_data = '0; #1;
    check("chg_fill_ok", {31'd0, rom_ok}, 32'd0);
    tick(); check("chg_idle_ok", {31'd0, rom_ok}, 32'd0);
    tick(); check("chg_req", {31'd0, sdram_req}, 32'd1);
    check("chg_addr", {14'd0, sdram_addr}, 32'h20);
    serve(32'h20202020);
    check("chg_20_data", rom_data, 32'h20202020);
    rom_addr = 18'h00010; #1;
    check("chg_10_data", rom_data, 32'h10101010);

    // Flush while waiting: returned word dropped, same address refetched
    rom_addr = 18'h00030;
    tick(); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; sdram_rdy = 1'b1; sdram_data = 32'h30303030;
    tick(); sdram_rdy = 1'b0; sdram_data = '0;
    tick(); check("flush_ok", {31'd0, rom_ok}, 32'd0);
    tick(); check("flush_req", {31'd0, sdram_req}, 32'd1);
    check("flush_addr", {14'd0, sdram_addr}, 32'h30);
    serve(32'h31313131);
    check("flush_refill", rom_data, 32'h31313131);

    // Timeout: 8 WAIT cycles, one IDLE, then the same address is requested again
    rom_addr = 18'h00040;
    tick(); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("to_wait_req", {31'd0, sdram_req}, 32'd0);
      tick();
    end
    check("to_idle_req", {31'd0, sdram_req}, 32'd0);
    tick(); check("to_reissue", {31'd0, sdram_req}, 32'd1);
    check("to_reissue_addr", {14'd0, sdram_addr}, 32'h40);

    // Asynchronous reset in the middle of WAIT
    sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    tick(); rom_addr = 18'h00030; #1;
    check("pre_rst_ok", {31'd0, rom_ok}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_rom_ok", {31'd0, rom_ok}, 32'd0);
    check("arst_rom_data", rom_data, 32'd0);
    check("arst_sdram_req", {31'd0, sdram_req}, 32'd0);
    check("arst_sdram_addr", {14'd0, sdram_addr}, 32'd0);
    rom_cs = 1'b0;
    tick(); tick(); rst = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
